// File: rtl/control_sequencer.sv
// Hardwired Moore control sequencer: fetch, decode and R-type execute strobes for the datapath.
// Optional single-step gating is compiled in with the SEQ_STEP_EN macro (adds the `step` input).
module control_sequencer #(
  parameter int REG_ADDR_W = 4,
  parameter int MEM_WAIT   = 0,
  parameter int CNT_W      = 16
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  run,
`ifdef SEQ_STEP_EN
  input  logic                  step,
`endif
  input  logic [31:0]           ir,
  output logic                  pc_out,
  output logic                  zlo_out,
  output logic                  mdr_out,
  output logic                  mar_in,
  output logic                  z_in,
  output logic                  pc_in,
  output logic                  mdr_in,
  output logic                  ir_in,
  output logic                  y_in,
  output logic                  inc_pc,
  output logic                  read,
  output logic [3:0]            alu_op,
  output logic                  r_out_en,
  output logic [REG_ADDR_W-1:0] r_out_sel,
  output logic                  r_in_en,
  output logic [REG_ADDR_W-1:0] r_in_sel,
  output logic                  halted,
  output logic                  illegal,
  output logic [CNT_W-1:0]      instr_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_HALT
  } state_e;

  localparam logic [4:0] OP_ALU_LO = 5'd3;
  localparam logic [4:0] OP_ALU_HI = 5'd8;
  localparam logic [4:0] OP_NOP    = 5'd26;
  localparam logic [4:0] OP_HALT   = 5'd27;
  localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

  state_e           state_q, state_d;
  logic [3:0]       wait_q, wait_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             advance;

  logic [4:0]            opcode;
  logic [REG_ADDR_W-1:0] ra_sel, rb_sel, rc_sel;
  logic                  is_alu;
  logic                  unused_ir_bits;

  assign opcode         = ir[31:27];
  assign ra_sel         = REG_ADDR_W'(ir[26:23]);
  assign rb_sel         = REG_ADDR_W'(ir[22:19]);
  assign rc_sel         = REG_ADDR_W'(ir[18:15]);
  assign is_alu         = (opcode >= OP_ALU_LO) && (opcode <= OP_ALU_HI);
  assign unused_ir_bits = ^ir[14:0];

`ifdef SEQ_STEP_EN
  assign advance = step;
`else
  assign advance = 1'b1;
`endif

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (clear) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      count_q <= '0;
    end else if (advance) begin
      state_q <= state_d;
      wait_q  <= wait_d;
      count_q <= count_d;
    end
  end

  assign instr_count = count_q;

  always_comb begin
    // NOTE: every output and next-state value gets a default first, so no path infers a latch.
    state_d   = state_q;
    wait_d    = wait_q;
    count_d   = count_q;
    pc_out    = 1'b0;
    zlo_out   = 1'b0;
    mdr_out   = 1'b0;
    mar_in    = 1'b0;
    z_in      = 1'b0;
    pc_in     = 1'b0;
    mdr_in    = 1'b0;
    ir_in     = 1'b0;
    y_in      = 1'b0;
    inc_pc    = 1'b0;
    read      = 1'b0;
    alu_op    = 4'h0;
    r_out_en  = 1'b0;
    r_out_sel = '0;
    r_in_en   = 1'b0;
    r_in_sel  = '0;
    halted    = 1'b0;
    illegal   = 1'b0;

    unique case (state_q)
      S_IDLE: if (run) state_d = S_T0;
      S_T0: begin
        pc_out  = 1'b1;
        mar_in  = 1'b1;
        inc_pc  = 1'b1;
        z_in    = 1'b1;
        wait_d  = WAIT_INIT;
        state_d = S_T1;
      end
      S_T1: begin
        read   = 1'b1;
        mdr_in = 1'b1;
        // The wait counter still holds its load value only on the first T1 cycle.
        if (wait_q == WAIT_INIT) begin
          zlo_out = 1'b1;
          pc_in   = 1'b1;
        end
        if (wait_q == 4'd0) state_d = S_T2;
        else                wait_d  = wait_q - 4'd1;
      end
      S_T2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        if (is_alu) begin
          r_out_en  = 1'b1;
          r_out_sel = rb_sel;
          y_in      = 1'b1;
          state_d   = S_T4;
        end else begin
          // NOP, HALT and undefined opcodes all retire here; undefined ones behave as NOP.
          count_d = count_q + CNT_W'(1);
          if (opcode == OP_HALT) begin
            state_d = S_HALT;
          end else begin
            illegal = (opcode != OP_NOP) && advance;
            state_d = S_T0;
          end
        end
      end
      S_T4: begin
        r_out_en  = 1'b1;
        r_out_sel = rc_sel;
        z_in      = 1'b1;
        alu_op    = opcode[3:0];
        state_d   = S_T5;
      end
      S_T5: begin
        zlo_out  = 1'b1;
        r_in_en  = 1'b1;
        r_in_sel = ra_sel;
        count_d  = count_q + CNT_W'(1);
        state_d  = S_T0;
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed vector table, hand-written corner
// sequences, and randomized traffic against an offset-based timeline model.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        run   = 1'b0;
  logic [31:0] ir    = 32'h0;
  logic        step  = 1'b1;

  always #5 clock = ~clock;

  // Strobe vector layout: pc_out zlo_out mdr_out mar_in z_in pc_in mdr_in ir_in y_in inc_pc read
  wire [10:0] strb_a, strb_b;
  wire [3:0]  alu_a, alu_b, ros_a, ros_b, ris_a, ris_b;
  wire        roe_a, roe_b, rie_a, rie_b, halt_a, halt_b, ill_a, ill_b;
  wire [15:0] cnt_a;
  wire [2:0]  cnt_b;
  wire [26:0] bundle_a = {strb_a, alu_a, roe_a, ros_a, rie_a, ris_a, halt_a, ill_a};
  wire [26:0] bundle_b = {strb_b, alu_b, roe_b, ros_b, rie_b, ris_b, halt_b, ill_b};

  control_sequencer #(.REG_ADDR_W(4), .MEM_WAIT(0), .CNT_W(16)) dut_a (
    .clock(clock), .clear(clear), .run(run),
`ifdef SEQ_STEP_EN
    .step(step),
`endif
    .ir(ir),
    .pc_out(strb_a[10]), .zlo_out(strb_a[9]), .mdr_out(strb_a[8]), .mar_in(strb_a[7]),
    .z_in(strb_a[6]), .pc_in(strb_a[5]), .mdr_in(strb_a[4]), .ir_in(strb_a[3]),
    .y_in(strb_a[2]), .inc_pc(strb_a[1]), .read(strb_a[0]),
    .alu_op(alu_a), .r_out_en(roe_a), .r_out_sel(ros_a), .r_in_en(rie_a), .r_in_sel(ris_a),
    .halted(halt_a), .illegal(ill_a), .instr_count(cnt_a)
  );

  control_sequencer #(.REG_ADDR_W(4), .MEM_WAIT(2), .CNT_W(3)) dut_b (
    .clock(clock), .clear(clear), .run(run),
`ifdef SEQ_STEP_EN
    .step(step),
`endif
    .ir(ir),
    .pc_out(strb_b[10]), .zlo_out(strb_b[9]), .mdr_out(strb_b[8]), .mar_in(strb_b[7]),
    .z_in(strb_b[6]), .pc_in(strb_b[5]), .mdr_in(strb_b[4]), .ir_in(strb_b[3]),
    .y_in(strb_b[2]), .inc_pc(strb_b[1]), .read(strb_b[0]),
    .alu_op(alu_b), .r_out_en(roe_b), .r_out_sel(ros_b), .r_in_en(rie_b), .r_in_sel(ris_b),
    .halted(halt_b), .illegal(ill_b), .instr_count(cnt_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    run   = 1'b0;
    cyc();
    clear = 1'b0;
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] a, b, c);
    return {op, a, b, c, 15'h0};
  endfunction

  // ---------------- reference model: instruction timeline by cycle offset ----------------
  bit mdl_idle [2];
  bit mdl_halt [2];
  int mdl_off  [2];
  int mdl_cnt  [2];
  int mdl_mw   [2] = '{0, 2};
  int mdl_cw   [2] = '{16, 3};

  // Offsets: 0 fetch address, 1..1+mw memory read, 2+mw IR load, 3+mw decode, then ALU steps.
  function automatic logic [26:0] model_out(input bit idle, input bit hlt, input int off,
                                            input int mw, input logic [31:0] iv, input bit stp);
    logic [10:0] s;
    logic [3:0]  alu, ros, ris;
    logic        roe, rie, ill;
    logic [4:0]  op;
    s = '0; alu = '0; ros = '0; ris = '0; roe = 0; rie = 0; ill = 0;
    op = iv[31:27];
    if (!idle && !hlt) begin
      if (off == 0) begin
        s[10] = 1; s[7] = 1; s[1] = 1; s[6] = 1;
      end else if (off <= 1 + mw) begin
        s[0] = 1; s[4] = 1;
        if (off == 1) begin s[9] = 1; s[5] = 1; end
      end else if (off == 2 + mw) begin
        s[8] = 1; s[3] = 1;
      end else if (off == 3 + mw) begin
        if (op >= 3 && op <= 8) begin roe = 1; ros = iv[22:19]; s[2] = 1; end
        else if (op != 26 && op != 27) ill = stp;
      end else if (off == 4 + mw) begin
        roe = 1; ros = iv[18:15]; s[6] = 1; alu = op[3:0];
      end else if (off == 5 + mw) begin
        s[9] = 1; rie = 1; ris = iv[26:23];
      end
    end
    return {s, alu, roe, ros, rie, ris, hlt && !idle, ill};
  endfunction

  task automatic model_step(input int i);
    logic [4:0] op;
    op = ir[31:27];
    if (clear) begin
      mdl_idle[i] = 1; mdl_halt[i] = 0; mdl_off[i] = 0; mdl_cnt[i] = 0;
    end else if (step) begin
      if (mdl_idle[i]) begin
        if (run) begin mdl_idle[i] = 0; mdl_off[i] = 0; end
      end else if (!mdl_halt[i]) begin
        if (mdl_off[i] == 3 + mdl_mw[i] && !(op >= 3 && op <= 8)) begin
          mdl_cnt[i] = (mdl_cnt[i] + 1) % (1 << mdl_cw[i]);
          if (op == 27) mdl_halt[i] = 1;
          else          mdl_off[i]  = 0;
        end else if (mdl_off[i] == 5 + mdl_mw[i]) begin
          mdl_cnt[i] = (mdl_cnt[i] + 1) % (1 << mdl_cw[i]);
          mdl_off[i] = 0;
        end else begin
          mdl_off[i]++;
        end
      end
    end
  endtask

  function automatic logic [31:0] rand_ir();
    int         r;
    logic [4:0] op;
    r = $urandom_range(99);
    if (r < 55)       op = 5'(3 + $urandom_range(5));
    else if (r < 65)  op = 5'd26;
    else if (r == 65) op = 5'd27;
    else begin
      op = 5'($urandom_range(31));
      if (op == 5'd27) op = 5'd26;
    end
    return {op, 27'($urandom)};
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] ir;
    int          len;
    logic [3:0]  alu;
    logic [3:0]  ra, rb, rc;
    bit          ill;
    bit          hlt;
  } vec_t;

  vec_t vt [9];

  initial begin
    int         pc_mask, ill_n, rie_n, roe_n, nz, halted_n, pc_n, unstable;
    logic [3:0] alu4, ros3, ros4, ris5;
    logic [31:0] cnt_end;
    bit         halt_end, seen7;
    logic [26:0] rec [24];
    int         rd_mask, mdr_mask, pcin_mask, pco_mask;

    vt[0] = '{32'h28918000, 6, 4'h5, 4'd1,  4'd2, 4'd3, 0, 0};
    vt[1] = '{mk(3, 4, 5, 6),   6, 4'h3, 4'd4,  4'd5, 4'd6, 0, 0};
    vt[2] = '{mk(8, 15, 0, 9),  6, 4'h8, 4'd15, 4'd0, 4'd9, 0, 0};
    vt[3] = '{mk(4, 7, 12, 14), 6, 4'h4, 4'd7,  4'd12, 4'd14, 0, 0};
    vt[4] = '{mk(26, 1, 2, 3),  4, 4'h0, 4'd0,  4'd0, 4'd0, 0, 0};
    vt[5] = '{32'hF8000000,     4, 4'h0, 4'd0,  4'd0, 4'd0, 1, 0};
    vt[6] = '{mk(9, 5, 6, 7),   4, 4'h0, 4'd0,  4'd0, 4'd0, 1, 0};
    vt[7] = '{mk(2, 5, 6, 7),   4, 4'h0, 4'd0,  4'd0, 4'd0, 1, 0};
    vt[8] = '{32'hD8000000,     4, 4'h0, 4'd0,  4'd0, 4'd0, 0, 1};

    // Reset state
    do_clear();
    @(negedge clock);
    check("reset_outputs_a", 32'(bundle_a), 32'h0);
    check("reset_count_a", 32'(cnt_a), 32'h0);
    check("reset_outputs_b", 32'(bundle_b), 32'h0);
    cyc();

    foreach (vt[i]) begin
      do_clear();
      ir  = vt[i].ir;
      run = 1'b1;
      cyc();
      run = 1'b0;
      pc_mask = 0; ill_n = 0; rie_n = 0; roe_n = 0;
      alu4 = 0; ros3 = 0; ros4 = 0; ris5 = 0; cnt_end = 0; halt_end = 0;
      for (int k = 0; k <= vt[i].len; k++) begin
        @(negedge clock);
        if (strb_a[10]) pc_mask |= (1 << k);
        ill_n += int'(ill_a);
        rie_n += int'(rie_a);
        roe_n += int'(roe_a);
        if (k == 3) ros3 = ros_a;
        if (k == 4) begin alu4 = alu_a; ros4 = ros_a; end
        if (k == 5) ris5 = ris_a;
        if (k == vt[i].len) begin cnt_end = 32'(cnt_a); halt_end = halt_a; end
        cyc();
      end
      check($sformatf("v%0d_t0_period", i), pc_mask, vt[i].hlt ? 1 : (1 | (1 << vt[i].len)));
      check($sformatf("v%0d_illegal_cycles", i), ill_n, vt[i].ill ? 1 : 0);
      check($sformatf("v%0d_r_in_en_cycles", i), rie_n, (vt[i].len == 6) ? 1 : 0);
      check($sformatf("v%0d_r_out_en_cycles", i), roe_n, (vt[i].len == 6) ? 2 : 0);
      check($sformatf("v%0d_count", i), cnt_end, 1);
      check($sformatf("v%0d_halted", i), 32'(halt_end), 32'(vt[i].hlt));
      if (vt[i].len == 6) begin
        check($sformatf("v%0d_t3_rb", i), ros3, vt[i].rb);
        check($sformatf("v%0d_t4_alu_op", i), alu4, vt[i].alu);
        check($sformatf("v%0d_t4_rc", i), ros4, vt[i].rc);
        check($sformatf("v%0d_t5_ra", i), ris5, vt[i].ra);
      end
    end

    // HALT holds for 20 cycles regardless of run
    do_clear();
    ir  = 32'hD8000000;
    run = 1'b1;
    cyc();
    run = 1'b0;
    repeat (4) cyc();
    halted_n = 0; pc_n = 0;
    for (int k = 0; k < 20; k++) begin
      run = k[0];
      @(negedge clock);
      halted_n += int'(halt_a);
      pc_n     += int'(strb_a[10]);
      cyc();
    end
    run = 1'b0;
    @(negedge clock);
    check("halt_held_cycles", halted_n, 20);
    check("halt_no_fetch", pc_n, 0);
    check("halt_count", 32'(cnt_a), 1);
    cyc();

    // clear in T4 of the second instruction, then clear+run together
    do_clear();
    ir  = 32'h28918000;
    run = 1'b1;
    cyc();
    run = 1'b0;
    repeat (10) cyc();
    @(negedge clock);
    check("pre_clear_in_t4", alu_a, 4'h5);
    check("pre_clear_count", 32'(cnt_a), 1);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    @(negedge clock);
    check("clear_outputs", 32'(bundle_a), 0);
    check("clear_count", 32'(cnt_a), 0);
    nz = 0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      @(negedge clock);
      nz += int'(bundle_a != 27'h0);
    end
    check("idle_after_clear", nz, 0);
    cyc();
    clear = 1'b1;
    run   = 1'b1;
    cyc();
    clear = 1'b0;
    @(negedge clock);
    check("clear_beats_run", strb_a[10], 1'b0);
    cyc();
    run = 1'b0;
    @(negedge clock);
    check("run_after_clear_t0", strb_a[10], 1'b1);
    cyc();

    // MEM_WAIT=2 read window and loop length
    do_clear();
    ir  = 32'h28918000;
    run = 1'b1;
    cyc();
    run = 1'b0;
    rd_mask = 0; mdr_mask = 0; pcin_mask = 0; pco_mask = 0;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clock);
      if (strb_b[0])  rd_mask   |= (1 << k);
      if (strb_b[4])  mdr_mask  |= (1 << k);
      if (strb_b[5])  pcin_mask |= (1 << k);
      if (strb_b[10]) pco_mask  |= (1 << k);
      cyc();
    end
    check("wait2_read_window", rd_mask, 32'hE);
    check("wait2_mdr_in_window", mdr_mask, 32'hE);
    check("wait2_pc_in_first_only", pcin_mask, 32'h2);
    check("wait2_loop_length", pco_mask, 32'h101);

    // Counter wrap on the 3-bit instance: nine NOPs of 6 cycles each
    do_clear();
    ir  = mk(26, 0, 0, 0);
    run = 1'b1;
    cyc();
    run = 1'b0;
    seen7 = 0;
    for (int k = 0; k < 54; k++) begin
      @(negedge clock);
      if (cnt_b == 3'd7) seen7 = 1;
      cyc();
    end
    @(negedge clock);
    check("wrap_reached_max", 32'(seen7), 1);
    check("wrap_count", 32'(cnt_b), 1);
    check("wrap_at_t0", strb_b[10], 1'b1);
    cyc();

`ifdef SEQ_STEP_EN
    // Step every third cycle: each state persists 3 cycles, ADD completes after 6 steps
    do_clear();
    ir  = 32'h28918000;
    run = 1'b1;
    pc_mask = 0; cnt_end = 0;
    for (int c = 0; c < 24; c++) begin
      step = (c % 3 == 2);
      @(negedge clock);
      rec[c] = bundle_a;
      if (strb_a[10]) pc_mask |= (1 << c);
      if (c == 21) cnt_end = 32'(cnt_a);
      cyc();
    end
    run  = 1'b0;
    step = 1'b1;
    unstable = 0;
    for (int g = 0; g < 8; g++)
      if (rec[3*g] != rec[3*g+1] || rec[3*g] != rec[3*g+2]) unstable++;
    check("step_t0_cycles", pc_mask, 32'h00E00038);
    check("step_outputs_stable", unstable, 0);
    check("step_count", cnt_end, 1);
`endif

    // Randomized traffic against the timeline model (both instances)
    do_clear();
    for (int i = 0; i < 2; i++) begin
      mdl_idle[i] = 1; mdl_halt[i] = 0; mdl_off[i] = 0; mdl_cnt[i] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      clear = ($urandom_range(63) == 0);
      run   = ($urandom_range(3) == 0);
      ir    = rand_ir();
`ifdef SEQ_STEP_EN
      step  = 1'($urandom_range(1));
`endif
      @(negedge clock);
      check("rand_outputs_a", 32'(bundle_a),
            32'(model_out(mdl_idle[0], mdl_halt[0], mdl_off[0], mdl_mw[0], ir, step)));
      check("rand_count_a", 32'(cnt_a), mdl_cnt[0]);
      check("rand_outputs_b", 32'(bundle_b),
            32'(model_out(mdl_idle[1], mdl_halt[1], mdl_off[1], mdl_mw[1], ir, step)));
      check("rand_count_b", 32'(cnt_b), mdl_cnt[1]);
      model_step(0);
      model_step(1);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
